// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier: one operand pair per start,
// WIDTH iterations through a single time-shared adder, one-cycle done pulse.
module seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_L,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               last_iter;

    // The edge that sees count==WIDTH-1 performs the final iteration.
    assign last_iter = (count == CW'(WIDTH - 1));

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                CALC: begin
                    // Runs all WIDTH iterations even once mplier is zero.
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign product = acc;
endmodule
